nmcu_instr_scheduler: RTL and testbench

Front-end sequencer of the NMCU. It accepts one `instruction_t` at a time from the chiplet CPU link and decodes the opcode. It then drives the NMCU memory port (LOAD/STORE) or the MAC engine (MAC) to completion and returns exactly one `nmcu_cpu_resp_t` per accepted instruction. It sits between the interconnect receive logic and the memory/MAC datapath.

---
 rtl/instr_pkg.sv | 38 +++
 rtl/nmcu_pkg.sv | 6 +
 rtl/nmcu_instr_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_nmcu_instr_scheduler.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Instruction and response formats exchanged with the chiplet CPU link.
package instr_pkg;
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_MAC   = 3'd3,
        OP_HALT  = 3'd4
    } opcode_t;

    localparam logic [1:0] RESP_OK   = 2'd0;
    localparam logic [1:0] RESP_ERR  = 2'd1;
    localparam logic [1:0] RESP_BUSY = 2'd2;

    typedef struct packed {
        opcode_t                         opcode;
        logic [nmcu_pkg::ADDR_WIDTH-1:0] addr_a;
        logic [nmcu_pkg::ADDR_WIDTH-1:0] addr_b;
        logic [nmcu_pkg::ADDR_WIDTH-1:0] addr_c;
        logic [nmcu_pkg::DATA_WIDTH-1:0] data;
        logic [nmcu_pkg::LEN_WIDTH-1:0]  len;
    } instruction_t;

    typedef struct packed {
        logic                            valid;
        logic [nmcu_pkg::DATA_WIDTH-1:0] data;
        logic [1:0]                      status;
    } nmcu_cpu_resp_t;

    function automatic nmcu_cpu_resp_t mk_resp(input logic [nmcu_pkg::DATA_WIDTH-1:0] d,
                                               input logic [1:0] s);
        nmcu_cpu_resp_t r;
        r.valid  = 1'b1;
        r.data   = d;
        r.status = s;
        return r;
    endfunction
endpackage

// File: rtl/nmcu_pkg.sv
// Datapath widths shared by the NMCU blocks.
package nmcu_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;
    localparam int LEN_WIDTH  = 8;
endpackage

// File: rtl/nmcu_instr_scheduler.sv
// NMCU front-end sequencer: accepts one instruction at a time, runs it on the
// memory port or MAC engine, and returns exactly one response per instruction.
module nmcu_instr_scheduler
    import nmcu_pkg::*;
    import instr_pkg::*;
#(
    parameter int unsigned MAC_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  instruction_t          instr_i,
    output nmcu_cpu_resp_t        resp_o,
    input  logic                  resp_ready_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  mac_start_o,
    output logic [ADDR_WIDTH-1:0] mac_addr_a_o,
    output logic [ADDR_WIDTH-1:0] mac_addr_b_o,
    output logic [ADDR_WIDTH-1:0] mac_addr_c_o,
    output logic [DATA_WIDTH-1:0] mac_dim_o,
    output logic [LEN_WIDTH-1:0]  mac_len_o,
    input  logic                  mac_done_i,
    output logic                  halted_o,
    output logic [2:0]            dbg_state_o
);
    // Handshakes: instr moves on instr_valid_i & instr_ready_o, resp on
    // resp_o.valid & resp_ready_i, memory on mem_req_o & mem_gnt_i; a valid
    // side holds its payload stable until the matching ready/grant is seen.
    typedef enum logic [2:0] {
        S_IDLE, S_LD_REQ, S_LD_WAIT, S_ST_REQ, S_MAC_RUN, S_RESP, S_HALTED
    } state_e;

    localparam int TW = (MAC_TIMEOUT > 1) ? $clog2(MAC_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(MAC_TIMEOUT - 1);

    state_e                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [TW-1:0]         tcnt;
    logic                  halt_pend;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  cnt_last;

    // Address of the following word; wraps naturally at the address width.
    assign next_addr   = base_q + ADDR_WIDTH'(cnt) + ADDR_WIDTH'(1);
    assign cnt_last    = (cnt == len_q - LEN_WIDTH'(1));
    assign dbg_state_o = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            cnt           <= '0;
            tcnt          <= '0;
            halt_pend     <= 1'b0;
            instr_ready_o <= 1'b0;
            resp_o        <= '0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            mac_start_o   <= 1'b0;
            mac_addr_a_o  <= '0;
            mac_addr_b_o  <= '0;
            mac_addr_c_o  <= '0;
            mac_dim_o     <= '0;
            mac_len_o     <= '0;
            halted_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid_i && instr_ready_o) begin
                        instr_ready_o <= 1'b0;
                        base_q        <= instr_i.addr_a;
                        len_q         <= instr_i.len;
                        cnt           <= '0;
                        state         <= S_RESP;
                        case (instr_i.opcode)
                            OP_NOP:  resp_o <= mk_resp('0, RESP_OK);
                            OP_HALT: begin
                                resp_o    <= mk_resp('0, RESP_OK);
                                halt_pend <= 1'b1;
                            end
                            OP_LOAD, OP_STORE: begin
                                if (instr_i.len == '0) begin
                                    resp_o <= mk_resp('0, RESP_ERR);
                                end else begin
                                    state       <= (instr_i.opcode == OP_LOAD) ? S_LD_REQ : S_ST_REQ;
                                    mem_req_o   <= 1'b1;
                                    mem_we_o    <= (instr_i.opcode == OP_STORE);
                                    mem_addr_o  <= instr_i.addr_a;
                                    mem_wdata_o <= instr_i.data;
                                end
                            end
                            OP_MAC: begin
                                state        <= S_MAC_RUN;
                                mac_start_o  <= 1'b1;
                                mac_addr_a_o <= instr_i.addr_a;
                                mac_addr_b_o <= instr_i.addr_b;
                                mac_addr_c_o <= instr_i.addr_c;
                                mac_dim_o    <= instr_i.data;
                                mac_len_o    <= instr_i.len;
                                tcnt         <= '0;
                            end
                            default: resp_o <= mk_resp('0, RESP_ERR);
                        endcase
                    end else begin
                        instr_ready_o <= 1'b1;
                    end
                end
                S_LD_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= S_LD_WAIT;
                    end
                end
                S_LD_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (cnt_last) begin
                            resp_o <= mk_resp(mem_rdata_i, RESP_OK);
                            state  <= S_RESP;
                        end else begin
                            cnt        <= cnt + LEN_WIDTH'(1);
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= next_addr;
                            state      <= S_LD_REQ;
                        end
                    end
                end
                S_ST_REQ: begin
                    if (mem_gnt_i) begin
                        if (cnt_last) begin
                            mem_req_o <= 1'b0;
                            mem_we_o  <= 1'b0;
                            resp_o    <= mk_resp('0, RESP_OK);
                            state     <= S_RESP;
                        end else begin
                            cnt        <= cnt + LEN_WIDTH'(1);
                            mem_addr_o <= next_addr;
                        end
                    end
                end
                S_MAC_RUN: begin
                    mac_start_o <= 1'b0;
                    // Done wins over a timeout landing in the same cycle.
                    if (mac_done_i) begin
                        resp_o <= mk_resp('0, RESP_OK);
                        state  <= S_RESP;
                    end else if (tcnt == T_LAST) begin
                        resp_o <= mk_resp('0, RESP_ERR);
                        state  <= S_RESP;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_o.valid <= 1'b0;
                        if (halt_pend) begin
                            state    <= S_HALTED;
                            halted_o <= 1'b1;
                        end else begin
                            state         <= S_IDLE;
                            instr_ready_o <= 1'b1;
                        end
                    end
                end
                S_HALTED: begin
                    halted_o      <= 1'b1;
                    instr_ready_o <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nmcu_instr_scheduler.sv
// Bench for nmcu_instr_scheduler: vector table for single-cycle instructions,
// a memory responder with random stalls, and an independent reference model.
module tb_nmcu_instr_scheduler;
    import nmcu_pkg::*;
    import instr_pkg::*;

    localparam int MT = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  instr_valid_i;
    logic                  instr_ready_o;
    instruction_t          instr_i;
    nmcu_cpu_resp_t        resp_o;
    logic                  resp_ready_i;
    logic                  mem_req_o, mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i, mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mac_start_o;
    logic [ADDR_WIDTH-1:0] mac_addr_a_o, mac_addr_b_o, mac_addr_c_o;
    logic [DATA_WIDTH-1:0] mac_dim_o;
    logic [LEN_WIDTH-1:0]  mac_len_o;
    logic                  mac_done_i;
    logic                  halted_o;
    logic [2:0]            dbg_state;

    always #5 clk = ~clk;

    nmcu_instr_scheduler #(.MAC_TIMEOUT(MT)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
        .resp_o(resp_o), .resp_ready_i(resp_ready_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mac_start_o(mac_start_o),
        .mac_addr_a_o(mac_addr_a_o), .mac_addr_b_o(mac_addr_b_o), .mac_addr_c_o(mac_addr_c_o),
        .mac_dim_o(mac_dim_o), .mac_len_o(mac_len_o), .mac_done_i(mac_done_i),
        .halted_o(halted_o), .dbg_state_o(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- memory responder ----------------
    int  max_gnt_dly = 0;
    int  max_rd_dly  = 0;
    bit  gnt_block   = 1'b0;
    bit  rd_block    = 1'b0;
    logic [DATA_WIDTH-1:0] preset_mem [int];
    logic [DATA_WIDTH-1:0] wr_mem [int];
    logic [48:0] log_q [$];

    function automatic logic [DATA_WIDTH-1:0] init_word(input int a);
        return 32'hD00D_0000 ^ (a * 32'h0000_9E37);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] dev_read(input int a);
        if (wr_mem.exists(a)) return wr_mem[a];
        if (preset_mem.exists(a)) return preset_mem[a];
        return init_word(a);
    endfunction

    bit waiting = 1'b0;
    int g_dly = 0;
    bit rd_pend = 1'b0;
    int rd_dly = 0;
    logic [DATA_WIDTH-1:0] rd_data = '0;

    always @(negedge clk) begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        if (!rst_n) begin
            waiting = 1'b0;
            rd_pend = 1'b0;
        end else begin
            if (rd_pend) begin
                if (rd_dly == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rd_data;
                    rd_pend      = 1'b0;
                end else rd_dly--;
            end
            if (mem_req_o && !gnt_block) begin
                if (!waiting) begin
                    waiting = 1'b1;
                    g_dly   = $urandom_range(0, max_gnt_dly);
                end
                if (g_dly == 0) begin
                    mem_gnt_i = 1'b1;
                    waiting   = 1'b0;
                    if (mem_we_o) begin
                        wr_mem[int'(mem_addr_o)] = mem_wdata_o;
                        log_q.push_back({1'b1, mem_addr_o, mem_wdata_o});
                    end else begin
                        log_q.push_back({1'b0, mem_addr_o, 32'h0});
                        rd_pend = 1'b1;
                        rd_data = dev_read(int'(mem_addr_o));
                        rd_dly  = rd_block ? 1000000 : int'($urandom_range(0, max_rd_dly));
                    end
                end else g_dly--;
            end
        end
    end

    // Cycle counters sampled at the active edge (pre-update values).
    int req_cycles = 0, start_pulses = 0, resp_cycles = 0;
    always @(posedge clk) begin
        if (mem_req_o) req_cycles++;
        if (mac_start_o) start_pulses++;
        if (resp_o.valid) resp_cycles++;
    end

    // ---------------- reference model ----------------
    logic [DATA_WIDTH-1:0] ref_mem [int];
    logic [48:0] exp_q [$];
    int log_rd = 0;

    function automatic logic [DATA_WIDTH-1:0] ref_read(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        if (preset_mem.exists(a)) return preset_mem[a];
        return init_word(a);
    endfunction

    task automatic model(input instruction_t ins, output logic [1:0] st, output logic [31:0] d);
        st = RESP_OK;
        d  = '0;
        case (ins.opcode)
            OP_NOP, OP_HALT, OP_MAC: st = RESP_OK;
            OP_LOAD, OP_STORE: begin
                if (ins.len == 0) st = RESP_ERR;
                for (int i = 0; i < int'(ins.len); i++) begin
                    int a;
                    a = (int'(ins.addr_a) + i) % 65536;
                    if (ins.opcode == OP_STORE) begin
                        ref_mem[a] = ins.data;
                        exp_q.push_back({1'b1, 16'(a), ins.data});
                    end else begin
                        d = ref_read(a);
                        exp_q.push_back({1'b0, 16'(a), 32'h0});
                    end
                end
            end
            default: st = RESP_ERR;
        endcase
    endtask

    task automatic compare_log(input string nm);
        while (exp_q.size() > 0) begin
            logic [48:0] e;
            e = exp_q.pop_front();
            if (log_rd < log_q.size()) begin
                check({nm, "_access"}, log_q[log_rd], e);
                log_rd++;
            end else begin
                check({nm, "_missing_access"}, 64'h0, e);
            end
        end
        check({nm, "_extra_accesses"}, 64'(log_q.size() - log_rd), 64'h0);
        log_rd = log_q.size();
    endtask

    // ---------------- driver tasks ----------------
    function automatic instruction_t rand_instr(input opcode_t op, input logic [7:0] len);
        instruction_t i;
        i.opcode = op;
        i.addr_a = 16'($urandom);
        i.addr_b = 16'($urandom);
        i.addr_c = 16'($urandom);
        i.data   = $urandom;
        i.len    = len;
        return i;
    endfunction

    // Returns at the falling edge of the cycle after acceptance.
    task automatic issue(input instruction_t ins);
        int n = 0;
        while (!instr_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready_o) check("ready_timeout", 64'(instr_ready_o), 64'h1);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        @(posedge clk);
        @(negedge clk);
        instr_valid_i = 1'b0;
        instr_i       = '0;
    endtask

    // Latency 1 means valid in the first cycle after acceptance.
    task automatic wait_resp(output nmcu_cpu_resp_t r, output int lat);
        lat = 1;
        while (!resp_o.valid && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_o.valid) check("resp_timeout", 64'(resp_o.valid), 64'h1);
        r = resp_o;
        @(negedge clk);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_ctrl"}, {59'h0, instr_ready_o, mem_req_o, mem_we_o, mac_start_o, halted_o}, 64'h0);
        check({nm, "_resp"}, 64'(resp_o), 64'h0);
        check({nm, "_mem"}, {mem_addr_o, mem_wdata_o}, 64'h0);
        check({nm, "_mac_addr"}, {mac_addr_a_o, mac_addr_b_o, mac_addr_c_o}, 64'h0);
        check({nm, "_mac_cfg"}, {mac_dim_o, mac_len_o}, 64'h0);
    endtask

    task automatic run_mem(input string nm, input instruction_t ins, input int exp_lat);
        nmcu_cpu_resp_t r;
        logic [1:0] st;
        logic [31:0] d;
        int lat;
        model(ins, st, d);
        issue(ins);
        wait_resp(r, lat);
        check({nm, "_status"}, 64'(r.status), 64'(st));
        check({nm, "_data"}, 64'(r.data), 64'(d));
        if (exp_lat > 0) check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        compare_log(nm);
    endtask

    task automatic mac_run(input string nm, input int done_at, input logic [1:0] exp_st, input int exp_lat);
        instruction_t ins;
        int s0, n, bad;
        ins = rand_instr(OP_MAC, 8'($urandom));
        s0  = start_pulses;
        bad = 0;
        n   = 0;
        issue(ins);
        check({nm, "_start_first_cycle"}, 64'(mac_start_o), 64'h1);
        while (!resp_o.valid && n < 40) begin
            if ({mac_addr_a_o, mac_addr_b_o, mac_addr_c_o, mac_dim_o, mac_len_o} !==
                {ins.addr_a, ins.addr_b, ins.addr_c, ins.data, ins.len}) bad++;
            if (n == done_at) mac_done_i = 1'b1;
            @(negedge clk);
            mac_done_i = 1'b0;
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'(exp_lat));
        check({nm, "_status"}, 64'(resp_o.status), 64'(exp_st));
        check({nm, "_data"}, 64'(resp_o.data), 64'h0);
        check({nm, "_cfg_stable"}, 64'(bad), 64'h0);
        @(negedge clk);
        check({nm, "_start_pulses"}, 64'(start_pulses - s0), 64'h1);
    endtask

    typedef struct {
        opcode_t    op;
        logic [7:0] len;
        logic [1:0] st;
    } vec_t;

    initial begin
        vec_t vecs[7];
        instruction_t ins;
        nmcu_cpu_resp_t r, r0;
        int lat, r0c, bad;

        instr_valid_i = 1'b0;
        instr_i       = '0;
        resp_ready_i  = 1'b1;
        mac_done_i    = 1'b0;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(instr_ready_o), 64'h1);

        // ---------------- single-cycle instruction table ----------------
        vecs[0] = '{OP_NOP,         8'd0, RESP_OK};
        vecs[1] = '{OP_NOP,         8'd9, RESP_OK};
        vecs[2] = '{OP_LOAD,        8'd0, RESP_ERR};
        vecs[3] = '{OP_STORE,       8'd0, RESP_ERR};
        vecs[4] = '{opcode_t'(3'h5), 8'd3, RESP_ERR};
        vecs[5] = '{opcode_t'(3'h6), 8'd1, RESP_ERR};
        vecs[6] = '{opcode_t'(3'h7), 8'd4, RESP_ERR};
        foreach (vecs[i]) begin
            string nm;
            nm  = $sformatf("vec%0d", i);
            r0c = req_cycles;
            issue(rand_instr(vecs[i].op, vecs[i].len));
            wait_resp(r, lat);
            check({nm, "_latency"}, 64'(lat), 64'h1);
            check({nm, "_status"}, 64'(r.status), 64'(vecs[i].st));
            check({nm, "_data"}, 64'(r.data), 64'h0);
            check({nm, "_no_mem_req"}, 64'(req_cycles - r0c), 64'h0);
            check({nm, "_ready_again"}, 64'(instr_ready_o), 64'h1);
        end

        // ---------------- LOAD with stalls ----------------
        preset_mem[16'h10] = 32'hA;
        preset_mem[16'h11] = 32'hB;
        preset_mem[16'h12] = 32'hC;
        max_gnt_dly = 3;
        max_rd_dly  = 2;
        ins = rand_instr(OP_LOAD, 8'd3);
        ins.addr_a = 16'h0010;
        run_mem("load_stall", ins, 0);

        // ---------------- STORE wrap ----------------
        ins = rand_instr(OP_STORE, 8'd2);
        ins.addr_a = 16'hFFFF;
        ins.data   = 32'h55;
        run_mem("store_wrap", ins, 0);

        // ---------------- zero-latency memory ----------------
        max_gnt_dly = 0;
        max_rd_dly  = 0;
        run_mem("load_zero_lat", rand_instr(OP_LOAD, 8'd4), 9);
        run_mem("store_zero_lat", rand_instr(OP_STORE, 8'd3), 4);
        run_mem("load_one_word", rand_instr(OP_LOAD, 8'd1), 3);

        // ---------------- MAC ----------------
        mac_run("mac_done5", 5, RESP_OK, 6);
        mac_run("mac_timeout", -1, RESP_ERR, MT);
        mac_run("mac_done_at_timeout", MT - 1, RESP_OK, MT);
        mac_run("mac_done_at_start", 0, RESP_OK, 1);

        // ---------------- randomized LOAD/STORE ----------------
        max_gnt_dly = 3;
        max_rd_dly  = 3;
        for (int k = 0; k < 25; k++) begin
            ins = rand_instr($urandom_range(0, 1) ? OP_LOAD : OP_STORE, 8'($urandom_range(1, 5)));
            if ($urandom_range(0, 1) == 1) ins.addr_a = 16'hFFFF - 16'($urandom_range(0, 3));
            run_mem($sformatf("rand%0d", k), ins, 0);
        end

        // ---------------- reset mid-operation ----------------
        gnt_block = 1'b1;
        issue(rand_instr(OP_STORE, 8'd2));
        check("st_req_before_reset", 64'(mem_req_o), 64'h1);
        #2 rst_n = 1'b0;
        #1 check("st_req_async_drop", 64'(mem_req_o), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        gnt_block = 1'b0;
        max_gnt_dly = 0;
        rd_block = 1'b1;
        @(negedge clk);
        issue(rand_instr(OP_LOAD, 8'd2));
        @(negedge clk);
        r0c = resp_cycles;
        #2 rst_n = 1'b0;
        #1 check("ld_wait_reset_outputs", {61'h0, mem_req_o, resp_o.valid, instr_ready_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_block = 1'b0;
        repeat (6) @(negedge clk);
        check("abandoned_no_resp", 64'(resp_cycles - r0c), 64'h0);
        check("ready_after_abort", 64'(instr_ready_o), 64'h1);
        log_rd = log_q.size();

        // ---------------- HALT with held response ----------------
        resp_ready_i = 1'b0;
        issue(rand_instr(OP_HALT, 8'($urandom)));
        r0 = resp_o;
        check("halt_resp", 64'(r0), 64'({1'b1, 32'h0, RESP_OK}));
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_o !== r0) bad++;
        end
        check("halt_resp_stable", 64'(bad), 64'h0);
        resp_ready_i = 1'b1;
        @(negedge clk);
        check("halted_state", {62'h0, halted_o, instr_ready_o}, 64'h2);
        r0c = resp_cycles;
        bad = 0;
        instr_valid_i = 1'b1;
        instr_i = rand_instr(OP_NOP, 8'd0);
        repeat (5) begin
            @(negedge clk);
            if (instr_ready_o || !halted_o) bad++;
        end
        instr_valid_i = 1'b0;
        check("halted_sticky", 64'(bad), 64'h0);
        check("halted_no_resp", 64'(resp_cycles - r0c), 64'h0);

        // ---------------- final reset ----------------
        #2 rst_n = 1'b0;
        #1 check_zero("reset_from_halt");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_final_reset", 64'(instr_ready_o), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
